// File: rtl/paper_regs_axi_lite.sv
// AXI4-Lite 64-bit register slave for the Paper window: ID, CTRL, STATUS, SCRATCH,
// plus PENDING/ENABLE and a level interrupt when PAPER_REGS_IRQ_EN is defined.
module paper_regs_axi_lite #(
  parameter logic [63:0] BaseAddr  = 64'h1900_0000,
  parameter logic [63:0] WinLength = 64'h1000,
  parameter int unsigned NumEvents = 8,
  parameter logic [63:0] IdValue   = 64'h5041_5045_0000_0001
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [63:0]          aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [63:0]          w_data_i,
  input  logic [7:0]           w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [63:0]          ar_addr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [63:0]          r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [63:0]          ctrl_o,
  input  logic [63:0]          status_i,
  input  logic [NumEvents-1:0] event_i,
  output logic                 irq_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [63:0] OFF_ID      = 64'h000;
  localparam logic [63:0] OFF_CTRL    = 64'h008;
  localparam logic [63:0] OFF_STATUS  = 64'h010;
  localparam logic [63:0] OFF_SCRATCH = 64'h018;
`ifdef PAPER_REGS_IRQ_EN
  localparam logic [63:0] OFF_PENDING = 64'h020;
  localparam logic [63:0] OFF_ENABLE  = 64'h028;
`endif

  function automatic logic [1:0] decode_resp(input logic [63:0] addr, input logic is_wr);
    logic [63:0] off;
    off = addr - BaseAddr;
    if (addr < BaseAddr || off >= WinLength) return RESP_DECERR;
    if (addr[2:0] != 3'b000) return RESP_SLVERR;
    case (off)
      OFF_ID, OFF_STATUS:    return is_wr ? RESP_SLVERR : RESP_OKAY;
      OFF_CTRL, OFF_SCRATCH: return RESP_OKAY;
`ifdef PAPER_REGS_IRQ_EN
      OFF_PENDING, OFF_ENABLE: return RESP_OKAY;
`endif
      default:               return RESP_SLVERR;
    endcase
  endfunction

  // Handshakes: a beat transfers on a rising clk edge where valid && ready are both 1.
  // The slave holds b/r valid and payload stable until the matching ready is seen.
  logic [0:0]  w_state_q, r_state_q;
  logic        aw_held_q, w_held_q;
  logic [63:0] aw_addr_q, w_data_q;
  logic [7:0]  w_strb_q;
  logic [63:0] ctrl_q, scratch_q;

  logic        aw_fire, w_fire, aw_have, w_have, wr_go, wr_ok, ar_fire;
  logic [63:0] wr_addr, wr_data, wr_off, wr_mask, ar_off, rd_val;
  logic [7:0]  wr_strb;
  logic [1:0]  wr_resp, rd_resp;

  assign aw_fire = aw_valid_i && aw_ready_o;
  assign w_fire  = w_valid_i && w_ready_o;
  assign aw_have = aw_held_q || aw_fire;
  assign w_have  = w_held_q || w_fire;
  assign wr_go   = (w_state_q == W_IDLE) && aw_have && w_have;
  assign wr_addr = aw_held_q ? aw_addr_q : aw_addr_i;
  assign wr_data = w_held_q ? w_data_q : w_data_i;
  assign wr_strb = w_held_q ? w_strb_q : w_strb_i;
  assign wr_off  = wr_addr - BaseAddr;
  assign wr_resp = decode_resp(wr_addr, 1'b1);
  assign wr_ok   = wr_go && (wr_resp == RESP_OKAY);

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < 8; i++) wr_mask[8*i +: 8] = {8{wr_strb[i]}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_o <= 1'b0;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_resp_o   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr_q <= aw_addr_i;
            aw_held_q <= 1'b1;
          end
          if (w_fire) begin
            w_data_q <= w_data_i;
            w_strb_q <= w_strb_i;
            w_held_q <= 1'b1;
          end
          if (wr_go) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b0;
            b_valid_o  <= 1'b1;
            b_resp_o   <= wr_resp;
            w_state_q  <= W_RESP;
          end else begin
            aw_ready_o <= !aw_have;
            w_ready_o  <= !w_have;
          end
        end
        default: begin
          if (b_ready_i) begin
            b_valid_o  <= 1'b0;
            aw_ready_o <= 1'b1;
            w_ready_o  <= 1'b1;
            w_state_q  <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
    end else begin
      if (wr_ok && wr_off == OFF_CTRL)    ctrl_q    <= (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
      if (wr_ok && wr_off == OFF_SCRATCH) scratch_q <= (scratch_q & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign ctrl_o = ctrl_q;

`ifdef PAPER_REGS_IRQ_EN
  logic [NumEvents-1:0] pending_q, enable_q, w1c_mask, en_mask, en_data;
  logic [63:0]          wr_masked, pend_ext, en_ext;
  logic                 irq_q;

  assign wr_masked = wr_data & wr_mask;
  assign w1c_mask  = (wr_ok && wr_off == OFF_PENDING) ? wr_masked[NumEvents-1:0] : '0;
  assign en_mask   = wr_mask[NumEvents-1:0];
  assign en_data   = wr_data[NumEvents-1:0];

  // A clear and a new event on the same bit in one cycle leave the bit set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      enable_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~w1c_mask) | event_i;
      if (wr_ok && wr_off == OFF_ENABLE) enable_q <= (enable_q & ~en_mask) | (en_data & en_mask);
      irq_q <= |(pending_q & enable_q);
    end
  end

  always_comb begin
    pend_ext = '0;
    en_ext   = '0;
    pend_ext[NumEvents-1:0] = pending_q;
    en_ext[NumEvents-1:0]   = enable_q;
  end

  assign irq_o = irq_q;
`else
  logic unused_event;
  assign unused_event = ^event_i;
  assign irq_o = 1'b0;
`endif

  assign ar_fire = ar_valid_i && ar_ready_o;
  assign ar_off  = ar_addr_i - BaseAddr;
  assign rd_resp = decode_resp(ar_addr_i, 1'b0);

  always_comb begin
    rd_val = '0;
    case (ar_off)
      OFF_ID:      rd_val = IdValue;
      OFF_CTRL:    rd_val = ctrl_q;
      OFF_STATUS:  rd_val = status_i;
      OFF_SCRATCH: rd_val = scratch_q;
`ifdef PAPER_REGS_IRQ_EN
      OFF_PENDING: rd_val = pend_ext;
      OFF_ENABLE:  rd_val = en_ext;
`endif
      default:     rd_val = '0;
    endcase
  end

  // Data is captured at the AR handshake, so a same-cycle write is not yet visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      ar_ready_o <= 1'b0;
      r_valid_o  <= 1'b0;
      r_data_o   <= '0;
      r_resp_o   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            r_data_o   <= (rd_resp == RESP_OKAY) ? rd_val : 64'h0;
            r_resp_o   <= rd_resp;
            r_valid_o  <= 1'b1;
            ar_ready_o <= 1'b0;
            r_state_q  <= R_RESP;
          end else begin
            ar_ready_o <= 1'b1;
          end
        end
        default: begin
          if (r_ready_i) begin
            r_valid_o  <= 1'b0;
            ar_ready_o <= 1'b1;
            r_state_q  <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
